// File: rtl/sally_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sally_bus_ctrl
//
// CPU-side bus controller for the 6502C ("Sally") socket. It takes the video
// chip's halt/ready/interrupt requests and phase strobes and turns them into a
// per-cycle clock enable, a bus-ownership flag and a stretched NMI for the
// T65 core. It follows Sally semantics:
//   - HALT is taken only at the end of a read cycle. Pending writes drain first.
//   - READY stretches reads only.
//   - An int_b falling edge becomes an NMI that lasts NMI_HOLD CPU cycles.
//
// Parameters
//   NMI_HOLD      cpu_ce pulses for which cpu_nmi_n stays low (1..7)
//   MAX_WR        deferred writes tolerated before halt_overrun is flagged
//
// Ports
//   clk_sys       system clock, all state on its rising edge
//   reset         synchronous, active-high reset
//   pclk0         one-clk strobe, end of CPU cycle (decision point)
//   pclk1         one-clk strobe, mid cycle (halt_b / ready sample point)
//   halt_b        active-low halt request
//   ready         active-high ready, low stretches read cycles
//   int_b         active-low interrupt, falling-edge sensitive
//   cpu_rw        R/W of the CPU's current cycle (1 = read)
//   line_clr      one-clk strobe at line start, clears halted_cycles
//   cpu_ce        one-clk enable advancing the CPU by one cycle
//   cpu_nmi_n     active-low NMI to the CPU
//   cpu_bus_en    1 = CPU owns the bus, 0 = bus released for DMA
//   halted        1 while halted
//   halt_overrun  sticky, more than MAX_WR writes were deferred
//   halted_cycles CPU cycles spent halted since last line_clr (saturating)
// -----------------------------------------------------------------------------
module sally_bus_ctrl #(
  parameter int NMI_HOLD = 2,
  parameter int MAX_WR   = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        pclk0,
  input  logic        pclk1,
  input  logic        halt_b,
  input  logic        ready,
  input  logic        int_b,
  input  logic        cpu_rw,
  input  logic        line_clr,
  output logic        cpu_ce,
  output logic        cpu_nmi_n,
  output logic        cpu_bus_en,
  output logic        halted,
  output logic        halt_overrun,
  output logic [12:0] halted_cycles
);

  localparam logic [1:0]  ST_RUN       = 2'd0;
  localparam logic [1:0]  ST_HALT_PEND = 2'd1;
  localparam logic [1:0]  ST_HALTED    = 2'd2;

  localparam logic [2:0]  NMI_LOAD  = 3'(NMI_HOLD);
  localparam logic [3:0]  WR_LIMIT  = 4'(MAX_WR);
  localparam logic [12:0] HC_MAX    = 13'h1fff;

  logic [1:0] state;
  logic       halt_req;
  logic       rdy_s;
  logic [2:0] wr_cnt;
  logic [2:0] wr_next;
  logic [2:0] nmi_cnt;
  logic       int_q;

  // Saturating write counter: a long write burst under halt must not wrap
  // back below the overrun limit.
  assign wr_next = (wr_cnt == 3'd7) ? 3'd7 : wr_cnt + 3'd1;

  assign cpu_nmi_n = (nmi_cnt == 3'd0);

  // NOTE: every register below is assigned with <= so that all of them
  // update from the same pre-edge values; mixing in blocking assignments
  // would make the result depend on statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= ST_RUN;
      halt_req      <= 1'b0;
      rdy_s         <= 1'b1;
      wr_cnt        <= 3'd0;
      nmi_cnt       <= 3'd0;
      int_q         <= 1'b1;
      cpu_ce        <= 1'b0;
      cpu_bus_en    <= 1'b1;
      halted        <= 1'b0;
      halt_overrun  <= 1'b0;
      halted_cycles <= 13'd0;
    end else begin
      int_q <= int_b;

      // Requests are only looked at mid-cycle, so decisions at pclk0 see a
      // value that was stable for the second half of the CPU cycle.
      if (pclk1) begin
        halt_req <= ~halt_b;
        rdy_s    <= ready;
      end

      // cpu_ce is a single-clk pulse: default low, raised only at pclk0.
      cpu_ce <= 1'b0;

      if (pclk0) begin
        case (state)
          ST_RUN: begin
            if (halt_req && cpu_rw) begin
              // Abort the read; the CPU repeats it after release.
              state      <= ST_HALTED;
              cpu_bus_en <= 1'b0;
              halted     <= 1'b1;
            end else if (halt_req) begin
              // A write cannot be aborted; let it finish and wait for a read.
              cpu_ce <= 1'b1;
              wr_cnt <= 3'd1;
              state  <= ST_HALT_PEND;
            end else if (rdy_s || !cpu_rw) begin
              cpu_ce <= 1'b1;
            end
          end
          ST_HALT_PEND: begin
            // Halt is committed here; halt_req is deliberately ignored.
            if (!cpu_rw) begin
              cpu_ce <= 1'b1;
              wr_cnt <= wr_next;
              if ({1'b0, wr_next} > WR_LIMIT) halt_overrun <= 1'b1;
            end else begin
              state      <= ST_HALTED;
              cpu_bus_en <= 1'b0;
              halted     <= 1'b1;
            end
          end
          ST_HALTED: begin
            if (!halt_req) begin
              // Release cycle: bus comes back, but the CPU only advances on
              // the next pclk0.
              state      <= ST_RUN;
              cpu_bus_en <= 1'b1;
              halted     <= 1'b0;
            end
          end
          default: begin
            state      <= ST_RUN;
            cpu_bus_en <= 1'b1;
            halted     <= 1'b0;
          end
        endcase
      end

      // line_clr has priority over a coincident increment.
      if (line_clr) begin
        halted_cycles <= 13'd0;
      end else if (pclk0 && state == ST_HALTED && halt_req &&
                   halted_cycles != HC_MAX) begin
        halted_cycles <= halted_cycles + 13'd1;
      end

      // A fresh edge reloads the hold count even mid-pulse; otherwise the
      // count only runs down on real CPU cycles, so halts and stalls stretch
      // the NMI.
      if (int_q && !int_b) begin
        nmi_cnt <= NMI_LOAD;
      end else if (cpu_ce && nmi_cnt != 3'd0) begin
        nmi_cnt <= nmi_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sally_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sally_bus_ctrl
//
// Drives whole CPU cycles (inputs, pclk1, optional idle clks, pclk0) and
// compares the DUT against a cycle-level reference model of the bus
// controller. Directed sequences cover halt/release, write deferral, ready
// stretch, NMI stretching, line_clr, counter saturation and reset mid-halt,
// followed by randomized cycles.
// -----------------------------------------------------------------------------
module tb_sally_bus_ctrl;

  localparam int NMI_HOLD = 2;
  localparam int MAX_WR   = 3;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        pclk0    = 1'b0;
  logic        pclk1    = 1'b0;
  logic        halt_b   = 1'b1;
  logic        ready    = 1'b1;
  logic        int_b    = 1'b1;
  logic        cpu_rw   = 1'b1;
  logic        line_clr = 1'b0;
  logic        cpu_ce;
  logic        cpu_nmi_n;
  logic        cpu_bus_en;
  logic        halted;
  logic        halt_overrun;
  logic [12:0] halted_cycles;

  sally_bus_ctrl #(.NMI_HOLD(NMI_HOLD), .MAX_WR(MAX_WR)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .pclk0        (pclk0),
    .pclk1        (pclk1),
    .halt_b       (halt_b),
    .ready        (ready),
    .int_b        (int_b),
    .cpu_rw       (cpu_rw),
    .line_clr     (line_clr),
    .cpu_ce       (cpu_ce),
    .cpu_nmi_n    (cpu_nmi_n),
    .cpu_bus_en   (cpu_bus_en),
    .halted       (halted),
    .halt_overrun (halt_overrun),
    .halted_cycles(halted_cycles)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per CPU cycle) ----------------
  typedef enum {M_CPU, M_DRAIN, M_DMA} owner_t;

  owner_t m_mode;
  bit     m_hr, m_rdy;
  int     m_wr, m_hc, m_nmi;
  bit     m_ovr, m_ce, m_bus, m_halted;
  bit     m_prev_int, m_prev_ce;

  task automatic model_reset();
    m_mode = M_CPU;   m_hr = 0;  m_rdy = 1; m_wr = 0; m_hc = 0; m_nmi = 0;
    m_ovr = 0; m_ce = 0; m_bus = 1; m_halted = 0;
    m_prev_int = 1;   m_prev_ce = 0;
  endtask

  task automatic model_end_of_cycle(input bit rw, input bit lc);
    m_ce = 0;
    case (m_mode)
      M_CPU: begin
        if (m_hr && rw)      begin m_mode = M_DMA; m_bus = 0; m_halted = 1; end
        else if (m_hr)       begin m_ce = 1; m_wr = 1; m_mode = M_DRAIN; end
        else if (m_rdy || !rw) m_ce = 1;
      end
      M_DRAIN: begin
        if (!rw) begin
          m_ce = 1;
          if (m_wr < 7) m_wr++;
          if (m_wr > MAX_WR) m_ovr = 1;
        end else begin
          m_mode = M_DMA; m_bus = 0; m_halted = 1;
        end
      end
      M_DMA: begin
        if (!m_hr) begin m_mode = M_CPU; m_bus = 1; m_halted = 0; end
        else if (m_hc < 8191) m_hc++;
      end
    endcase
    if (lc) m_hc = 0;
  endtask

  // One CPU cycle. Entered and left at a falling clk edge.
  task automatic cycle(input bit hb, input bit rdy, input bit rw, input bit ib,
                       input bit lc, input int gap);
    halt_b = hb; ready = rdy; cpu_rw = rw; int_b = ib;
    @(posedge clk_sys);
    // Previous cycle's enable retires onto the NMI count; a new edge overrides.
    if (m_prev_ce && m_nmi > 0) m_nmi--;
    if (m_prev_int && !ib) m_nmi = NMI_HOLD;
    m_prev_int = ib;
    #1;
    check("ce_single_clk", cpu_ce, 0);
    check("nmi_n_start", cpu_nmi_n, (m_nmi == 0));
    @(negedge clk_sys);
    pclk1 = 1'b1;
    @(posedge clk_sys);
    m_hr = !hb; m_rdy = rdy;
    @(negedge clk_sys);
    pclk1 = 1'b0;
    repeat (gap) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
    end
    pclk0 = 1'b1; line_clr = lc;
    @(posedge clk_sys);
    model_end_of_cycle(rw, lc);
    #1;
    check("cpu_ce",        cpu_ce,        m_ce);
    check("cpu_bus_en",    cpu_bus_en,    m_bus);
    check("halted",        halted,        m_halted);
    check("halt_overrun",  halt_overrun,  m_ovr);
    check("halted_cycles", halted_cycles, m_hc);
    check("cpu_nmi_n",     cpu_nmi_n,     (m_nmi == 0));
    @(negedge clk_sys);
    pclk0 = 1'b0; line_clr = 1'b0;
    m_prev_ce = m_ce;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_sys);
    model_reset();
    #1;
    check("rst_cpu_ce",        cpu_ce,        0);
    check("rst_cpu_nmi_n",     cpu_nmi_n,     1);
    check("rst_cpu_bus_en",    cpu_bus_en,    1);
    check("rst_halted",        halted,        0);
    check("rst_halt_overrun",  halt_overrun,  0);
    check("rst_halted_cycles", halted_cycles, 0);
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hb_r, ib_r;
    model_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    do_reset();

    // Halt on read, 5 halted cycles, release, first enable after release.
    cycle(1, 1, 1, 1, 0, 1);
    check("pre_halt_ce", cpu_ce, 1);
    cycle(0, 1, 1, 1, 0, 1);
    check("halt_rd_ce", cpu_ce, 0);
    check("halt_rd_bus", cpu_bus_en, 0);
    check("halt_rd_halted", halted, 1);
    repeat (5) cycle(0, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    check("release_hc", halted_cycles, 5);
    check("release_bus", cpu_bus_en, 1);
    check("release_ce", cpu_ce, 0);
    cycle(1, 1, 1, 1, 0, 2);
    check("post_release_ce", cpu_ce, 1);

    // Three deferred writes then a read: no overrun.
    repeat (3) begin
      cycle(0, 1, 0, 1, 0, 0);
      check("defer_wr_ce", cpu_ce, 1);
    end
    cycle(0, 1, 1, 1, 0, 0);
    check("defer3_halted", halted, 1);
    check("defer3_ovr", halt_overrun, 0);
    cycle(1, 1, 1, 1, 0, 0);

    // Four deferred writes: overrun, sticky.
    repeat (4) cycle(0, 1, 0, 1, 0, 1);
    cycle(0, 1, 1, 1, 0, 0);
    check("defer4_ovr", halt_overrun, 1);
    cycle(1, 1, 1, 1, 0, 0);
    repeat (3) cycle(1, 1, 1, 1, 0, 0);
    check("ovr_sticky", halt_overrun, 1);

    // Ready stretch on reads, ignored on writes.
    cycle(1, 0, 1, 1, 0, 0);
    check("stretch_rd1", cpu_ce, 0);
    cycle(1, 0, 1, 1, 0, 0);
    check("stretch_rd2", cpu_ce, 0);
    cycle(1, 1, 1, 1, 0, 0);
    check("stretch_end", cpu_ce, 1);
    cycle(1, 0, 0, 1, 0, 0);
    check("stretch_wr1", cpu_ce, 1);
    cycle(1, 0, 0, 1, 0, 0);
    check("stretch_wr2", cpu_ce, 1);

    // NMI: low for exactly two enables.
    cycle(1, 1, 1, 0, 0, 0);
    check("nmi_low1", cpu_nmi_n, 0);
    cycle(1, 1, 1, 0, 0, 0);
    check("nmi_low2", cpu_nmi_n, 0);
    cycle(1, 1, 1, 1, 0, 0);
    check("nmi_released", cpu_nmi_n, 1);

    // NMI stretched across a halt.
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (3) cycle(0, 1, 1, 0, 0, 0);
    check("nmi_in_halt", cpu_nmi_n, 0);
    cycle(1, 1, 1, 0, 0, 0);
    check("nmi_at_release", cpu_nmi_n, 0);
    cycle(1, 1, 1, 1, 0, 0);
    check("nmi_last_ce", cpu_ce, 1);
    cycle(1, 1, 1, 1, 0, 0);
    check("nmi_after_halt", cpu_nmi_n, 1);

    // line_clr coincident with pclk0 in HALTED.
    cycle(0, 1, 1, 1, 0, 0);
    repeat (3) cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 1, 0);
    check("line_clr_hc", halted_cycles, 0);

    // Reset while halted with the NMI count loaded.
    cycle(0, 1, 1, 0, 0, 0);
    check("pre_rst_nmi", cpu_nmi_n, 0);
    check("pre_rst_halted", halted, 1);
    do_reset();

    // Saturation of halted_cycles.
    cycle(1, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    repeat (8200) cycle(0, 1, 1, 1, 0, 0);
    check("hc_saturated", halted_cycles, 8191);
    cycle(1, 1, 1, 1, 0, 0);

    // Randomized cycles.
    hb_r = 1; ib_r = 1;
    repeat (600) begin
      if ($urandom_range(0, 4) == 0) hb_r = !hb_r;
      if ($urandom_range(0, 5) == 0) ib_r = !ib_r;
      cycle(hb_r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ib_r,
            ($urandom_range(0, 15) == 0), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sally_bus_ctrl.md
# sally_bus_ctrl

CPU-side bus controller for the 6502C ("Sally") socket: the receiving end of the video chip's `halt_b`, `ready`, `int_b` and phase strobes. It converts them into a per-cycle clock enable, a bus-ownership flag and an NMI line for the T65 core. It implements Sally semantics:
- HALT is honoured only at the end of a read cycle.
- READY stretches reads only.
- The interrupt edge is turned into a fixed-length NMI pulse.

It sits between `maria` and the CPU core in the top level.

## Interface
Parameters:
- NMI_HOLD, 2: number of `cpu_ce` pulses for which `cpu_nmi_n` is held low after an `int_b` falling edge (1..7).
- MAX_WR, 3: consecutive deferred write cycles allowed before `halt_overrun` is flagged.

Ports:
- clk_sys  in  1  system clock; all logic runs on this edge.
- reset  in  1  synchronous, active-high reset.
- pclk0  in  1  one-clk strobe marking the end of a CPU cycle.
- pclk1  in  1  one-clk strobe marking mid-cycle; input sample point.
- halt_b  in  1  active-low halt request from the video chip.
- ready  in  1  active-high ready; low stretches read cycles.
- int_b  in  1  active-low interrupt from the video chip; edge-sensitive here.
- cpu_rw  in  1  R/W of the CPU's current cycle (1 = read).
- line_clr  in  1  one-clk strobe at line start; clears `halted_cycles`.
- cpu_ce  out  1  one-clk enable advancing the T65 by one cycle.
- cpu_nmi_n  out  1  active-low NMI to the T65.
- cpu_bus_en  out  1  1 = CPU owns AB/DB/RW; 0 = bus released for DMA.
- halted  out  1  1 while in HALTED.
- halt_overrun  out  1  sticky; set when more than MAX_WR writes were deferred.
- halted_cycles  out  13  CPU cycles spent halted since the last `line_clr`; saturates at 8191.

## Operation
- Sampling: on `pclk1`, capture `halt_b` into `halt_req = ~halt_b` and `ready` into `rdy_s`. Decisions at `pclk0` use only these sampled values.
- States: RUN, HALT_PEND, HALTED.
- RUN at `pclk0`:
  - `halt_req` and `cpu_rw` = 1: abort the read. No `cpu_ce`; `cpu_bus_en` drops; go to HALTED. The read re-executes after release.
  - `halt_req` and `cpu_rw` = 0: issue `cpu_ce` so the write completes; set `wr_cnt` = 1; go to HALT_PEND.
  - No halt, `rdy_s` = 0 and `cpu_rw` = 1: stall. No `cpu_ce`; stay in RUN.
  - Otherwise: issue `cpu_ce`.
- HALT_PEND at `pclk0`:
  - `cpu_rw` = 0: issue `cpu_ce` and increment `wr_cnt`. If `wr_cnt` exceeds MAX_WR, set `halt_overrun`.
  - `cpu_rw` = 1: no `cpu_ce`; go to HALTED.
  - The halt is committed: deassertion of `halt_req` during HALT_PEND does not cancel it.
- HALTED:
  - At `pclk0` with `halt_req` = 0: `cpu_bus_en` = 1 on the same clk; go to RUN. No `cpu_ce` on this strobe.
  - Otherwise stay in HALTED and increment `halted_cycles` (saturating).
- Priority: halt over ready. `line_clr` clears `halted_cycles` and wins over a simultaneous increment.
- NMI:
  - `int_b` is registered every clk. A 1→0 transition loads `nmi_cnt` = NMI_HOLD.
  - `cpu_nmi_n` = (`nmi_cnt` == 0).
  - Each `cpu_ce` decrements a nonzero `nmi_cnt`.
  - A new edge while the count is nonzero reloads it to NMI_HOLD.
  - The count does not decrement while halted or stalled.
- Widths: `wr_cnt` is 3 bits and saturates at 7. `nmi_cnt` is 3 bits.

## Timing
- Reset values:
  - state RUN, `cpu_ce` 0, `cpu_nmi_n` 1, `cpu_bus_en` 1, `halted` 0, `halt_overrun` 0, `halted_cycles` 0.
  - Internal: `halt_req` 0, `rdy_s` 1, `wr_cnt` 0, `nmi_cnt` 0, registered `int_b` 1.
- `cpu_ce`, `cpu_bus_en` and `halted` change on the clk where `pclk0` is high; they are registered, visible one clk after the strobe.
- `cpu_ce` is high for exactly one clk per `pclk0` and never otherwise.
- Halt latency: `halt_b` low before a `pclk1` → bus released at the following `pclk0`, provided the cycle is a read.
- NMI latency: `cpu_nmi_n` falls one clk after the registered `int_b` edge. It rises on the clk after the NMI_HOLD-th `cpu_ce`.
- Simultaneous `pclk0` and `pclk1` never occur; behaviour in that case is undefined.
- Reset mid-halt: synchronous reset returns to RUN with the bus owned by the CPU. Any pending NMI is dropped.

## Test plan
- Halt on read: `halt_b` = 0 before `pclk1`, `cpu_rw` = 1 → at `pclk0` no `cpu_ce`; `cpu_bus_en` = 0 and `halted` = 1 one clk later. Release after 5 cycles → `halted_cycles` = 5, `cpu_bus_en` = 1, first `cpu_ce` on the next `pclk0`.
- Write deferral: halt requested during 3 consecutive writes then a read → three `cpu_ce` pulses, then HALTED, `halt_overrun` = 0. With 4 writes → `halt_overrun` = 1 and stays 1 until reset.
- Ready stretch: `ready` = 0 for 2 `pclk1`s on a read → 2 missing `cpu_ce` pulses. The same stimulus on a write → no missing pulses.
- NMI: `int_b` high→low with NMI_HOLD = 2 → `cpu_nmi_n` low for exactly 2 `cpu_ce` pulses. With a halt inserted between them → the low period extends across the halt.
- Counter: 8200 halted cycles → `halted_cycles` = 8191. `line_clr` coincident with `pclk0` in HALTED → 0.
- Reset while HALTED with `nmi_cnt` = 2 → next clk: `cpu_bus_en` = 1, `cpu_nmi_n` = 1, `halted_cycles` = 0.
